text_buffer_uart_dump: RTL

TEXT_BUFFER_UART_DUMP -- requirements
Module: text_buffer_uart_dump

---
 rtl/text_buffer_uart_dump.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/text_buffer_uart_dump.sv
// Streams a text-buffer RAM out of an 8N1 UART, one frame per cell.
// Optional CR/LF after every row when DUMP_LINE_BREAK_EN is defined.
module text_buffer_uart_dump #(
    parameter int CLKS_PER_BIT = 2604,
    parameter int COLS         = 80,
    parameter int CELLS        = 2400
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_Start,
    input  logic        i_Abort,
    output logic [11:0] o_Read_Address,
    input  logic [7:0]  i_Read_Data,
    output logic        o_UART_TX,
    output logic        o_Busy,
    output logic        o_Done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [11:0] LAST_ADDR = 12'(CELLS - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, LATCH, TX_START, TX_DATA, TX_STOP, NEXT
    } state_t;

    state_t state_q, state_d;

    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [11:0]   addr_q, addr_d;
    logic [7:0]    byte_q, byte_d;
    logic          tx_q, tx_d;
    logic          abort_q, abort_d;
    logic          done_q, done_d;

    logic baud_end;
    logic last_cell;
    logic abort_req;
    logic lb_more;

    assign baud_end  = (baud_q == BAUD_MAX);
    assign last_cell = (addr_q == LAST_ADDR);
    assign abort_req = abort_q | i_Abort;

`ifdef DUMP_LINE_BREAK_EN
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    logic [CW-1:0] col_q, col_d;
    logic [1:0]    lb_q, lb_d;
    logic          eol;

    assign eol     = (col_q == COL_LAST);
    // lb_q: 0 = cell frame, 1 = CR sent, 2 = LF sent
    assign lb_more = ((lb_q == 2'd0) && eol) || (lb_q == 2'd1);
`else
    assign lb_more = 1'b0;
`endif

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (i_Start) state_d = FETCH;
            FETCH:    state_d = i_Abort ? IDLE : LATCH;
            LATCH:    state_d = i_Abort ? IDLE : TX_START;
            TX_START: if (baud_end) state_d = TX_DATA;
            TX_DATA:  if (baud_end && bit_q == 3'd7) state_d = TX_STOP;
            TX_STOP:  if (baud_end) state_d = NEXT;
            NEXT: begin
                if (abort_req)      state_d = IDLE;
                else if (lb_more)   state_d = TX_START;
                else if (last_cell) state_d = IDLE;
                else                state_d = FETCH;
            end
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        o_Busy  = (state_q != IDLE);
        baud_d  = baud_q;
        bit_d   = bit_q;
        addr_d  = addr_q;
        byte_d  = byte_q;
        abort_d = abort_q;
        done_d  = 1'b0;
        tx_d    = 1'b1;
`ifdef DUMP_LINE_BREAK_EN
        col_d   = col_q;
        lb_d    = lb_q;
`endif
        unique case (state_q)
            IDLE: begin
                addr_d  = '0;
                baud_d  = '0;
                bit_d   = '0;
                abort_d = 1'b0;
`ifdef DUMP_LINE_BREAK_EN
                col_d   = '0;
                lb_d    = '0;
`endif
            end
            FETCH: ;
            LATCH: begin
                byte_d = (i_Read_Data == 8'h00) ? 8'h20 : i_Read_Data;
                baud_d = '0;
            end
            TX_START, TX_DATA, TX_STOP: begin
                abort_d = abort_req;
                baud_d  = baud_end ? '0 : baud_q + BW'(1);
                if (state_q == TX_START) tx_d = 1'b0;
                if (state_q == TX_DATA) begin
                    tx_d = byte_q[bit_q];
                    if (baud_end) bit_d = bit_q + 3'd1;
                end
            end
            NEXT: begin
                if (state_d == TX_START) begin
`ifdef DUMP_LINE_BREAK_EN
                    byte_d = (lb_q == 2'd0) ? 8'h0D : 8'h0A;
                    lb_d   = lb_q + 2'd1;
`endif
                end else if (state_d == FETCH) begin
                    addr_d = addr_q + 12'd1;
`ifdef DUMP_LINE_BREAK_EN
                    lb_d   = '0;
                    col_d  = eol ? '0 : col_q + CW'(1);
`endif
                end else begin
                    done_d = ~abort_req;
                end
            end
            default: ;
        endcase
    end

    // Line is registered from the current state, so it trails state by a cycle
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            baud_q  <= '0;
            bit_q   <= '0;
            addr_q  <= '0;
            byte_q  <= '0;
            tx_q    <= 1'b1;
            abort_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef DUMP_LINE_BREAK_EN
            col_q   <= '0;
            lb_q    <= '0;
`endif
        end else begin
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            addr_q  <= addr_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
            abort_q <= abort_d;
            done_q  <= done_d;
`ifdef DUMP_LINE_BREAK_EN
            col_q   <= col_d;
            lb_q    <= lb_d;
`endif
        end
    end

    assign o_Read_Address = addr_q;
    assign o_UART_TX      = tx_q;
    assign o_Done         = done_q;

endmodule
